// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter sharing one RAM port
// Fixed wait states, registered strobes, one-cycle ack per requester.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_r,
  output logic          ram_w,
  output logic [AW-1:0] ram_r_addr,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_line,
  input  logic [DW-1:0] ram_r_line,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [3:0]    counter;
  logic          last_grant;
  logic          we_q;
  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // A tie goes to the port that did not win the previous tie.
  always_comb begin
    winner    = (m0_req && m1_req) ? ~last_grant : m1_req;
    sel_we    = winner ? m1_we    : m0_we;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= '0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      ram_r      <= 1'b0;
      ram_w      <= 1'b0;
      ram_r_addr <= '0;
      ram_w_addr <= '0;
      ram_w_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            if (m0_req && m1_req) last_grant <= winner;
            grant_id <= winner;
            we_q     <= sel_we;
            counter  <= 4'(WAIT_STATES);
            busy     <= 1'b1;
            state    <= ACCESS;
            if (sel_we) begin
              ram_w      <= 1'b1;
              ram_w_addr <= sel_addr;
              ram_w_line <= sel_wdata;
            end else begin
              ram_r      <= 1'b1;
              ram_r_addr <= sel_addr;
            end
          end
        end
        ACCESS: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            // Read data is valid in the last held strobe cycle.
            if (!we_q) begin
              if (grant_id) m1_rdata <= ram_r_line;
              else          m0_rdata <= ram_r_line;
            end
            ram_r <= 1'b0;
            ram_w <= 1'b0;
            if (grant_id) m1_ack <= 1'b1;
            else          m0_ack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench, one arbiter per wait-state setting 0..3
// Timeline model of each transaction plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req [NI], m0_we [NI], m1_req [NI], m1_we [NI];
  logic [31:0] m0_addr [NI], m0_wdata [NI], m1_addr [NI], m1_wdata [NI];
  logic        m0_ack [NI], m1_ack [NI], ram_r [NI], ram_w [NI], busy [NI], grant_id [NI];
  logic [31:0] m0_rdata [NI], m1_rdata [NI], ram_r_addr [NI], ram_w_addr [NI];
  logic [31:0] ram_w_line [NI], ram_r_line [NI];

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign ram_r_line[g] = ram_data(ram_r_addr[g]);
    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(g)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
      .ram_r(ram_r[g]), .ram_w(ram_w[g]), .ram_r_addr(ram_r_addr[g]),
      .ram_w_addr(ram_w_addr[g]), .ram_w_line(ram_w_line[g]), .ram_r_line(ram_r_line[g]),
      .busy(busy[g]), .grant_id(grant_id[g])
    );
  end

  // Model: ph = cycles since the grant edge (-1 when no transaction is open).
  // Strobe for ph 0..W, ack at ph W+1, then back to idle.
  int          ph [NI];
  logic        lg [NI], win [NI], mwe [NI], e_gid [NI];
  logic [31:0] maddr [NI], e_rd0 [NI], e_rd1 [NI], e_raddr [NI], e_waddr [NI], e_wline [NI];
  logic        p_win [NI], p_we [NI];
  logic [31:0] p_addr [NI], p_wd [NI];
  logic        e_r [NI], e_w [NI], e_a0 [NI], e_a1 [NI], e_busy [NI];

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      p_win[k]  = (m0_req[k] && m1_req[k]) ? ~lg[k] : m1_req[k];
      p_we[k]   = p_win[k] ? m1_we[k]    : m0_we[k];
      p_addr[k] = p_win[k] ? m1_addr[k]  : m0_addr[k];
      p_wd[k]   = p_win[k] ? m1_wdata[k] : m0_wdata[k];
      e_r[k]    = (ph[k] >= 0) && (ph[k] <= k) && !mwe[k];
      e_w[k]    = (ph[k] >= 0) && (ph[k] <= k) && mwe[k];
      e_a0[k]   = (ph[k] == k + 1) && !win[k];
      e_a1[k]   = (ph[k] == k + 1) && win[k];
      e_busy[k] = (ph[k] >= 0);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        ph[k] <= -1; lg[k] <= 1'b1; win[k] <= 1'b0; mwe[k] <= 1'b0; maddr[k] <= '0;
        e_gid[k] <= 1'b0; e_rd0[k] <= '0; e_rd1[k] <= '0;
        e_raddr[k] <= '0; e_waddr[k] <= '0; e_wline[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (ph[k] < 0) begin
          if (m0_req[k] || m1_req[k]) begin
            if (m0_req[k] && m1_req[k]) lg[k] <= p_win[k];
            win[k] <= p_win[k]; e_gid[k] <= p_win[k];
            mwe[k] <= p_we[k]; maddr[k] <= p_addr[k];
            ph[k] <= 0;
            if (p_we[k]) begin
              e_waddr[k] <= p_addr[k]; e_wline[k] <= p_wd[k];
            end else begin
              e_raddr[k] <= p_addr[k];
            end
          end
        end else if (ph[k] < k) begin
          ph[k] <= ph[k] + 1;
        end else if (ph[k] == k) begin
          ph[k] <= k + 1;
          if (!mwe[k]) begin
            if (win[k]) e_rd1[k] <= ram_data(maddr[k]);
            else        e_rd0[k] <= ram_data(maddr[k]);
          end
        end else begin
          ph[k] <= -1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare and activity monitor.
  int cyc = 0;
  int r_cnt [NI], w_cnt [NI], bl_cnt [NI];
  int ack_k [$], ack_p [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("ctrl[%0d]", k),
          {26'd0, m0_ack[k], m1_ack[k], ram_r[k], ram_w[k], busy[k], grant_id[k]},
          {26'd0, e_a0[k], e_a1[k], e_r[k], e_w[k], e_busy[k], e_gid[k]});
      chk($sformatf("m0_rdata[%0d]", k), m0_rdata[k], e_rd0[k]);
      chk($sformatf("m1_rdata[%0d]", k), m1_rdata[k], e_rd1[k]);
      chk($sformatf("ram_r_addr[%0d]", k), ram_r_addr[k], e_raddr[k]);
      chk($sformatf("ram_w_addr[%0d]", k), ram_w_addr[k], e_waddr[k]);
      chk($sformatf("ram_w_line[%0d]", k), ram_w_line[k], e_wline[k]);
      if (ram_r[k]) r_cnt[k] <= r_cnt[k] + 1;
      if (ram_w[k]) w_cnt[k] <= w_cnt[k] + 1;
      if (!busy[k]) bl_cnt[k] <= bl_cnt[k] + 1;
      if (m0_ack[k]) begin ack_k.push_back(k); ack_p.push_back(0); end
      if (m1_ack[k]) begin ack_k.push_back(k); ack_p.push_back(1); end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, input int p, output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if ((p == 0) ? m0_ack[k] : m1_ack[k]) return;
    end
    chk($sformatf("ack_timeout[%0d].m%0d", k, p), 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  int n, s0, s1, acks, b0;
  logic [5:0] seq;
  logic [31:0] t4_exp [3];

  initial begin
    for (int k = 0; k < NI; k++) begin
      m0_req[k] = 0; m0_we[k] = 0; m0_addr[k] = '0; m0_wdata[k] = '0;
      m1_req[k] = 0; m1_we[k] = 0; m1_addr[k] = '0; m1_wdata[k] = '0;
    end
    #2 rst = 1'b0;
    tick(); tick();
    chk("reset_ctrl", {26'd0, m0_ack[1], m1_ack[1], ram_r[1], ram_w[1], busy[1], grant_id[1]}, 32'd0);
    chk("reset_rdata", m0_rdata[1], 32'd0);
    rst = 1'b1;
    tick();

    // W=1 read by M0
    s0 = r_cnt[1];
    m0_req[1] = 1; m0_we[1] = 0; m0_addr[1] = 32'h10;
    wait_ack(1, 0, n);
    m0_req[1] = 0;
    chk("t1_latency", n, 3);
    chk("t1_strobes", r_cnt[1] - s0, 2);
    chk("t1_rdata", m0_rdata[1], 32'hDEADBEEF);
    chk("t1_raddr", ram_r_addr[1], 32'h10);
    tick();

    // W=1 write by M1
    s0 = r_cnt[1]; s1 = w_cnt[1];
    m1_req[1] = 1; m1_we[1] = 1; m1_addr[1] = 32'h20; m1_wdata[1] = 32'h12345678;
    wait_ack(1, 1, n);
    m1_req[1] = 0; m1_we[1] = 0;
    chk("t2_latency", n, 3);
    chk("t2_wstrobes", w_cnt[1] - s1, 2);
    chk("t2_rstrobes", r_cnt[1] - s0, 0);
    chk("t2_waddr", ram_w_addr[1], 32'h20);
    chk("t2_wline", ram_w_line[1], 32'h12345678);
    chk("t2_m1_rdata", m1_rdata[1], 32'd0);
    chk("t2_raddr_kept", ram_r_addr[1], 32'h10);
    tick();

    // W=1 both requesters held: strict alternation starting with M0
    do_reset();
    s0 = ack_k.size();
    m0_req[1] = 1; m0_addr[1] = 32'h100;
    m1_req[1] = 1; m1_addr[1] = 32'h200; m1_we[1] = 0;
    acks = 0; n = 0;
    while (acks < 6 && n < 100) begin
      tick(); n++;
      acks = 0;
      for (int i = s0; i < ack_k.size(); i++) if (ack_k[i] == 1) acks++;
    end
    m0_req[1] = 0; m1_req[1] = 0;
    chk("t3_ack_count", acks, 6);
    seq = '0; acks = 0;
    for (int i = s0; i < ack_k.size(); i++)
      if (ack_k[i] == 1 && acks < 6) begin seq[acks] = ack_p[i][0]; acks++; end
    chk("t3_grant_order", {26'd0, seq}, 32'h2A);
    chk("t3_m0_rdata", m0_rdata[1], 32'hFEFF0100);
    chk("t3_m1_rdata", m1_rdata[1], 32'hFDFF0200);
    tick();

    // W=0 back-to-back reads by M0
    t4_exp[0] = 32'hFFFF0000; t4_exp[1] = 32'hFFFB0004; t4_exp[2] = 32'hFFF70008;
    m0_req[0] = 1; m0_we[0] = 0; m0_addr[0] = 32'h0;
    b0 = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ack(0, 0, n);
      chk($sformatf("t4_latency%0d", i), n, (i == 0) ? 2 : 3);
      chk($sformatf("t4_rdata%0d", i), m0_rdata[0], t4_exp[i]);
      if (i == 0) b0 = bl_cnt[0];
      m0_addr[0] = 32'h4 * (i + 1);
    end
    m0_req[0] = 0;
    chk("t4_busy_low", bl_cnt[0] - b0, 2);
    tick();

    // W=3 reset in the second access cycle abandons the transaction
    s0 = 0;
    for (int i = 0; i < ack_k.size(); i++) if (ack_k[i] == 3) s0++;
    m1_req[3] = 1; m1_we[3] = 0; m1_addr[3] = 32'h30;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("t5_reset_ctrl", {26'd0, m0_ack[3], m1_ack[3], ram_r[3], ram_w[3], busy[3], grant_id[3]}, 32'd0);
    chk("t5_reset_raddr", ram_r_addr[3], 32'd0);
    m1_req[3] = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    s1 = 0;
    for (int i = 0; i < ack_k.size(); i++) if (ack_k[i] == 3) s1++;
    chk("t5_no_ack", s1 - s0, 0);
    m0_req[3] = 1; m0_addr[3] = 32'h34;
    m1_req[3] = 1;
    wait_ack(3, 0, n);
    m0_req[3] = 0;
    chk("t5_tie_m0_latency", n, 5);
    chk("t5_m0_rdata", m0_rdata[3], 32'hFFCB0034);
    wait_ack(3, 1, n);
    m1_req[3] = 0;
    chk("t5_m1_latency", n, 6);
    tick();

    // W=2 read where M0 drops req one cycle in
    s0 = r_cnt[2];
    m0_req[2] = 1; m0_we[2] = 0; m0_addr[2] = 32'h40;
    tick();
    m0_req[2] = 0;
    wait_ack(2, 0, n);
    chk("t6_latency", n, 3);
    chk("t6_strobes", r_cnt[2] - s0, 3);
    chk("t6_rdata", m0_rdata[2], 32'hFFBF0040);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
